snake_scorer: RTL and testbench

SNAKE_SCORER -- requirements
Module: snake_scorer

---
 rtl/snake_scorer.sv | 136 +++++++++++++
 tb/tb_snake_scorer.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/snake_scorer.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : snake_scorer                                              |
// | Brief    : Game-state FSM, food-eat detection, saturating score,     |
// |            level derivation and high-score tracking for a snake game.|
// | Revision : 1.0 - initial release                                     |
// +----------------------------------------------------------------------+
module snake_scorer #(
  parameter int POS_W      = 6,
  parameter int N_FOOD     = 2,
  parameter int SCORE_W    = 8,
  parameter int LEVEL_STEP = 5,
  parameter int MAX_LEVEL  = 7
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  input  logic                    tick,
  input  logic                    game_over,
  input  logic [POS_W-1:0]        head,
  input  logic [N_FOOD*POS_W-1:0] food,
  input  logic [N_FOOD-1:0]       food_valid,
  output logic [N_FOOD-1:0]       gen,
  output logic [SCORE_W-1:0]      score,
  output logic [SCORE_W-1:0]      high_score,
  output logic [2:0]              level,
  output logic                    new_high,
  output logic [1:0]              state
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_OVER = 2'd2
  } state_t;

  localparam logic [SCORE_W-1:0] c_level_step = SCORE_W'(LEVEL_STEP);
  localparam logic [SCORE_W-1:0] c_max_level  = SCORE_W'(MAX_LEVEL);
  localparam logic [SCORE_W:0]   c_one        = {{SCORE_W{1'b0}}, 1'b1};
  localparam logic [SCORE_W-1:0] c_score_max  = {SCORE_W{1'b1}};

  state_t               state_q, state_d;
  logic [SCORE_W-1:0]   score_q, score_d;
  logic [SCORE_W-1:0]   high_score_q, high_score_d;
  logic [2:0]           level_q, level_d;
  logic [N_FOOD-1:0]    gen_q, gen_d;
  logic                 new_high_q, new_high_d;

  logic [N_FOOD-1:0]    match;
  logic [SCORE_W:0]     eat_cnt;
  logic [SCORE_W:0]     score_sum;
  logic [SCORE_W-1:0]   score_eat;
  logic [SCORE_W-1:0]   level_quo;

  // Eat detection and saturating score-plus-eaten value; only live in RUN on a tick.
  always_comb begin
    match   = '0;
    eat_cnt = '0;
    for (int i = 0; i < N_FOOD; i++) begin
      if ((state_q == ST_RUN) && tick && food_valid[i] &&
          (food[i*POS_W +: POS_W] == head)) begin
        match[i] = 1'b1;
        eat_cnt  = eat_cnt + c_one;
      end
    end
    score_sum = {1'b0, score_q} + eat_cnt;
    score_eat = score_sum[SCORE_W] ? c_score_max : score_sum[SCORE_W-1:0];
  end

  // Next-state, score, high-score and pulse outputs.
  always_comb begin
    state_d      = state_q;
    score_d      = score_q;
    high_score_d = high_score_q;
    gen_d        = '0;
    new_high_d   = 1'b0;
    case (state_q)
      ST_IDLE, ST_OVER: begin
        if (start) begin
          state_d = ST_RUN;
          score_d = '0;
          gen_d   = '1;
        end
      end
      ST_RUN: begin
        // Points from this tick land before the game-over decision sees the score.
        score_d = score_eat;
        gen_d   = match;
        if (game_over) begin
          state_d = ST_OVER;
          if (score_eat > high_score_q) begin
            high_score_d = score_eat;
            new_high_d   = 1'b1;
          end
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Level follows the next score so both registers update in the same cycle.
  always_comb begin
    level_quo = score_d / c_level_step;
    level_d   = (level_quo > c_max_level) ? c_max_level[2:0] : level_quo[2:0];
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      score_q      <= '0;
      high_score_q <= '0;
      level_q      <= '0;
      gen_q        <= '0;
      new_high_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      score_q      <= score_d;
      high_score_q <= high_score_d;
      level_q      <= level_d;
      gen_q        <= gen_d;
      new_high_q   <= new_high_d;
    end
  end

  assign gen        = gen_q;
  assign score      = score_q;
  assign high_score = high_score_q;
  assign level      = level_q;
  assign new_high   = new_high_q;
  assign state      = state_q;

endmodule
`default_nettype wire

// File: tb/tb_snake_scorer.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : tb_snake_scorer                                           |
// | Brief    : Directed self-checking bench for snake_scorer.            |
// | Revision : 1.0 - initial release                                     |
// +----------------------------------------------------------------------+
module tb_snake_scorer;

  logic        clk;
  logic        rst;
  logic        start;
  logic        tick;
  logic        game_over;
  logic [5:0]  head;
  logic [11:0] food;
  logic [1:0]  food_valid;
  logic [1:0]  gen;
  logic [7:0]  score;
  logic [7:0]  high_score;
  logic [2:0]  level;
  logic        new_high;
  logic [1:0]  state;

  int n_checks;
  int n_errors;

  snake_scorer #(
    .POS_W     (6),
    .N_FOOD    (2),
    .SCORE_W   (8),
    .LEVEL_STEP(5),
    .MAX_LEVEL (7)
  ) u_dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .tick      (tick),
    .game_over (game_over),
    .head      (head),
    .food      (food),
    .food_valid(food_valid),
    .gen       (gen),
    .score     (score),
    .high_score(high_score),
    .level     (level),
    .new_high  (new_high),
    .state     (state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Advance one clock; outputs are sampled 1 time unit after the rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_all(input string tag, input logic [1:0] st, input logic [7:0] sc,
                           input logic [7:0] hs, input logic [2:0] lv,
                           input logic [1:0] gn, input logic nh);
    check({tag, ".state"}, 32'(state), 32'(st));
    check({tag, ".score"}, 32'(score), 32'(sc));
    check({tag, ".high"}, 32'(high_score), 32'(hs));
    check({tag, ".level"}, 32'(level), 32'(lv));
    check({tag, ".gen"}, 32'(gen), 32'(gn));
    check({tag, ".new_high"}, 32'(new_high), 32'(nh));
  endtask

  initial begin
    n_checks   = 0;
    n_errors   = 0;
    rst        = 1'b1;
    start      = 1'b0;
    tick       = 1'b0;
    game_over  = 1'b0;
    head       = 6'd9;
    food       = {6'd9, 6'd9};
    food_valid = 2'b11;
    step();
    step();
    check_all("reset", 2'd0, 8'd0, 8'd0, 3'd0, 2'b00, 1'b0);
    rst = 1'b0;

    // tick and game_over are ignored in IDLE
    tick = 1'b1; game_over = 1'b1;
    step();
    tick = 1'b0; game_over = 1'b0;
    check_all("idle_tick", 2'd0, 8'd0, 8'd0, 3'd0, 2'b00, 1'b0);

    // start -> RUN, every food channel requested
    start = 1'b1;
    step();
    start = 1'b0;
    check_all("start", 2'd1, 8'd0, 8'd0, 3'd0, 2'b11, 1'b0);
    step();
    check("start_gen_clear", 32'(gen), 32'd0);

    // double match
    tick = 1'b1;
    step();
    tick = 1'b0;
    check("dbl.score", 32'(score), 32'd2);
    check("dbl.gen", 32'(gen), 32'd3);
    step();
    check("dbl.gen_clear", 32'(gen), 32'd0);

    // channel 0 matches position but is not valid; channel 1 elsewhere
    food = {6'd5, 6'd9}; food_valid = 2'b10; tick = 1'b1;
    step();
    check("invalid.score", 32'(score), 32'd2);
    check("invalid.gen", 32'(gen), 32'd0);

    // valid match but no tick
    food_valid = 2'b11; tick = 1'b0;
    step();
    check("notick.score", 32'(score), 32'd2);
    check("notick.gen", 32'(gen), 32'd0);

    // single match on channel 0 only, twice -> 4
    tick = 1'b1;
    step();
    check("single.score", 32'(score), 32'd3);
    check("single.gen", 32'(gen), 32'd1);
    step();
    check("single2.score", 32'(score), 32'd4);
    check("single2.level", 32'(level), 32'd0);

    // single match + game_over + start: points first, start ignored
    game_over = 1'b1; start = 1'b1;
    step();
    game_over = 1'b0; start = 1'b0; tick = 1'b0;
    check_all("over1", 2'd2, 8'd5, 8'd5, 3'd1, 2'b01, 1'b1);
    tick = 1'b1;
    step();
    tick = 1'b0;
    check_all("over1_hold", 2'd2, 8'd5, 8'd5, 3'd1, 2'b00, 1'b0);

    // second game ends at equal score -> no new high
    start = 1'b1;
    step();
    start = 1'b0;
    check_all("game2_start", 2'd1, 8'd0, 8'd5, 3'd0, 2'b11, 1'b0);
    food = {6'd9, 6'd9}; tick = 1'b1;
    step();
    step();
    food = {6'd5, 6'd9};
    step();
    tick = 1'b0;
    check("game2.score", 32'(score), 32'd5);
    game_over = 1'b1;
    step();
    game_over = 1'b0;
    check_all("game2_over", 2'd2, 8'd5, 8'd5, 3'd1, 2'b00, 1'b0);

    // third game: run to 254, then saturate
    start = 1'b1;
    step();
    start = 1'b0;
    food = {6'd9, 6'd9}; tick = 1'b1;
    for (int i = 0; i < 127; i++) step();
    check("sat.score254", 32'(score), 32'd254);
    check("sat.level254", 32'(level), 32'd7);
    step();
    check("sat.score255", 32'(score), 32'd255);
    step();
    tick = 1'b0;
    check_all("sat_hold", 2'd1, 8'd255, 8'd5, 3'd7, 2'b11, 1'b0);
    game_over = 1'b1;
    step();
    game_over = 1'b0;
    check_all("game3_over", 2'd2, 8'd255, 8'd255, 3'd7, 2'b00, 1'b1);

    // reset mid-RUN with eat and game_over in the reset cycle
    start = 1'b1;
    step();
    start = 1'b0;
    tick = 1'b1;
    step();
    check("game4.score", 32'(score), 32'd2);
    rst = 1'b1; game_over = 1'b1;
    step();
    rst = 1'b0; game_over = 1'b0; tick = 1'b0;
    check_all("mid_reset", 2'd0, 8'd0, 8'd0, 3'd0, 2'b00, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
